// File: rtl/feature_map_streamer.sv
// ---------------------------------------------------------------------------
// feature_map_streamer
//
// Streams one W x H feature map out of a synchronous-read memory, in
// row-major order starting at address 0, into line-buffer shift registers.
// Each read is issued in cycle t and its pixel is presented, together with
// the shift enable ce, in cycle t+1.
//
// Ports
//   clk          system clock, all logic on its rising edge
//   rst          synchronous active-high reset
//   start        one-cycle request to stream a map (honoured only in IDLE)
//   stall        while high, no new memory read is issued
//   mem_en       memory read enable
//   mem_addr     read address (row-major, base 0)
//   mem_data     read data, valid the cycle after mem_en
//   data_out     pixel to the line buffers (holds when ce = 0)
//   ce           shift enable, high exactly when data_out carries a new pixel
//   window_valid the pixel on data_out completes a full K x K window
//   busy         high in every state except IDLE
//   done         one-cycle completion pulse
//
// Handshake: start is a request sampled only in IDLE; there is no ready.
// stall is a throttle that blocks issuing a read in the same cycle, but a
// pixel already in flight (read issued last cycle) is always delivered.
// ---------------------------------------------------------------------------
module feature_map_streamer #(
   parameter int N      = 16,
   parameter int W      = 8,
   parameter int H      = 8,
   parameter int K      = 3,
   parameter int ADDR_W = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic              stall,
   output logic              mem_en,
   output logic [ADDR_W-1:0] mem_addr,
   input  logic [N-1:0]      mem_data,
   output logic [N-1:0]      data_out,
   output logic              ce,
   output logic              window_valid,
   output logic              busy,
   output logic              done
);

   localparam int NPIX = W * H;
   // One spare code so the counters can step past the last row/column
   // after the final pixel without wrapping into a valid position.
   localparam int CW = $clog2(W + 1);
   localparam int RW = $clog2(H + 1);

   localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NPIX - 1);
   localparam logic [CW-1:0]     COL_LAST  = CW'(W - 1);
   localparam logic [CW-1:0]     COL_MIN   = CW'(K - 1);
   localparam logic [RW-1:0]     ROW_MIN   = RW'(K - 1);

   localparam logic [1:0] S_IDLE   = 2'd0;
   localparam logic [1:0] S_STREAM = 2'd1;
   localparam logic [1:0] S_DRAIN  = 2'd2;
   localparam logic [1:0] S_DONE   = 2'd3;

   logic [1:0]        state;
   logic [ADDR_W-1:0] rd_addr;
   logic              ce_r;
   logic [N-1:0]      data_hold;
   logic [CW-1:0]     col;
   logic [RW-1:0]     row;
   logic              issue;
   logic              last_issue;

   // Reads are issued combinationally so stall takes effect in its own cycle.
   assign issue      = (state == S_STREAM) && !stall;
   assign last_issue = issue && (rd_addr == LAST_ADDR);

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= S_IDLE;
         rd_addr   <= '0;
         ce_r      <= 1'b0;
         data_hold <= '0;
         col       <= '0;
         row       <= '0;
      end else begin
         // ce follows the read by exactly one cycle, independent of stall.
         ce_r <= issue;

         // col/row name the pixel currently on data_out; step after it.
         if (ce_r) begin
            data_hold <= mem_data;
            if (col == COL_LAST) begin
               col <= '0;
               row <= row + 1'b1;
            end else begin
               col <= col + 1'b1;
            end
         end

         case (state)
            S_IDLE: begin
               if (start) begin
                  state   <= S_STREAM;
                  rd_addr <= '0;
                  col     <= '0;
                  row     <= '0;
               end
            end
            S_STREAM: begin
               if (last_issue) begin
                  // Address stays at the last valid location.
                  state <= S_DRAIN;
               end else if (issue) begin
                  rd_addr <= rd_addr + 1'b1;
               end
            end
            S_DRAIN: state <= S_DONE;
            S_DONE:  state <= S_IDLE;
            default: state <= S_IDLE;
         endcase
      end
   end

   assign mem_en       = issue;
   assign mem_addr     = rd_addr;
   assign ce           = ce_r;
   // Pass the read data straight through on ce; otherwise replay the last pixel.
   assign data_out     = ce_r ? mem_data : data_hold;
   assign window_valid = ce_r && (row >= ROW_MIN) && (col >= COL_MIN);
   assign busy         = (state != S_IDLE);
   assign done         = (state == S_DONE);

endmodule

// File: tb/tb_feature_map_streamer.sv
module tb_feature_map_streamer;

   localparam int N = 16;

   // ---------------- clock / reset ----------------
   logic clk = 1'b0;
   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   logic rst;

   // ---------------- 4x4 DUT ----------------
   logic          start4, stall4;
   logic          mem_en4;
   logic [15:0]   mem_addr4;
   logic [N-1:0]  mem_data4;
   logic [N-1:0]  data_out4;
   logic          ce4, wv4, busy4, done4;

   feature_map_streamer #(.N(N), .W(4), .H(4), .K(3), .ADDR_W(16)) dut4 (
      .clk(clk), .rst(rst), .start(start4), .stall(stall4),
      .mem_en(mem_en4), .mem_addr(mem_addr4), .mem_data(mem_data4),
      .data_out(data_out4), .ce(ce4), .window_valid(wv4),
      .busy(busy4), .done(done4)
   );

   // ---------------- default 8x8 DUT ----------------
   logic          start8, stall8;
   logic          mem_en8;
   logic [15:0]   mem_addr8;
   logic [N-1:0]  mem_data8;
   logic [N-1:0]  data_out8;
   logic          ce8, wv8, busy8, done8;

   feature_map_streamer dut8 (
      .clk(clk), .rst(rst), .start(start8), .stall(stall8),
      .mem_en(mem_en8), .mem_addr(mem_addr8), .mem_data(mem_data8),
      .data_out(data_out8), .ce(ce8), .window_valid(wv8),
      .busy(busy8), .done(done8)
   );

   // Memory models: mem[i] = i, one-cycle read latency.
   always @(posedge clk) begin
      if (mem_en4 === 1'b1) mem_data4 <= mem_addr4;
      if (mem_en8 === 1'b1) mem_data8 <= mem_addr8;
   end

   // ---------------- monitors (sample on falling edge) ----------------
   logic [N-1:0] ce_q[$];
   int           ce_cyc_q[$];
   logic [N-1:0] wv_q[$];
   int           done_cyc_q[$];
   int           en_during_stall;
   int           bad_addr;

   int ce8_cnt, wv8_cnt, done8_cnt, seq8_err;
   int max_addr8;

   always @(negedge clk) begin
      if (ce4 === 1'b1) begin
         ce_q.push_back(data_out4);
         ce_cyc_q.push_back(cyc);
      end
      if (wv4 === 1'b1) wv_q.push_back(data_out4);
      if (done4 === 1'b1) done_cyc_q.push_back(cyc);
      if (mem_en4 === 1'b1 && stall4 === 1'b1) en_during_stall++;
      if (mem_en4 === 1'b1 && mem_addr4 >= 16) bad_addr++;

      if (ce8 === 1'b1) begin
         if (data_out8 !== N'(ce8_cnt)) seq8_err++;
         ce8_cnt++;
      end
      if (wv8 === 1'b1) wv8_cnt++;
      if (done8 === 1'b1) done8_cnt++;
      if (mem_en8 === 1'b1 && int'(mem_addr8) > max_addr8) max_addr8 = int'(mem_addr8);
   end

   // ---------------- scoreboard counters ----------------
   int n_checks = 0;
   int n_fail   = 0;

   // ---------------- driver tasks ----------------
   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic clear_mon;
      ce_q.delete();
      ce_cyc_q.delete();
      wv_q.delete();
      done_cyc_q.delete();
      en_during_stall = 0;
      bad_addr = 0;
   endtask

   task automatic wait_done4(input int ndone, input int budget);
      int k;
      k = 0;
      while (done_cyc_q.size() < ndone && k < budget) begin
         tick();
         k++;
      end
   endtask

   // ---------------- tests ----------------
   task automatic test_reset;
      rst = 1'b1; start4 = 1'b0; stall4 = 1'b0; start8 = 1'b0; stall8 = 1'b0;
      tick(); tick();
      n_checks++; if (mem_en4 !== 1'b0) begin n_fail++; $display("FAIL reset_mem_en got %b exp 0", mem_en4); end
      n_checks++; if (mem_addr4 !== 16'd0) begin n_fail++; $display("FAIL reset_mem_addr got %0d exp 0", mem_addr4); end
      n_checks++; if (data_out4 !== '0) begin n_fail++; $display("FAIL reset_data_out got %0d exp 0", data_out4); end
      n_checks++; if (ce4 !== 1'b0) begin n_fail++; $display("FAIL reset_ce got %b exp 0", ce4); end
      n_checks++; if (wv4 !== 1'b0) begin n_fail++; $display("FAIL reset_window_valid got %b exp 0", wv4); end
      n_checks++; if (busy4 !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %b exp 0", busy4); end
      n_checks++; if (done4 !== 1'b0) begin n_fail++; $display("FAIL reset_done got %b exp 0", done4); end
      n_checks++; if (busy8 !== 1'b0 || ce8 !== 1'b0 || mem_addr8 !== 16'd0) begin
         n_fail++; $display("FAIL reset_dut8 got busy=%b ce=%b addr=%0d exp 0/0/0", busy8, ce8, mem_addr8);
      end
      rst = 1'b0;
      tick(); tick();
      n_checks++; if (busy4 !== 1'b0 || mem_en4 !== 1'b0) begin
         n_fail++; $display("FAIL idle_after_reset got busy=%b mem_en=%b exp 0/0", busy4, mem_en4);
      end
   endtask

   task automatic test_basic;
      int t;
      logic [N-1:0] exp_q[$];
      clear_mon();
      start4 = 1'b1; t = cyc; tick(); start4 = 1'b0;
      n_checks++; if (busy4 !== 1'b1) begin n_fail++; $display("FAIL basic_busy got %b exp 1", busy4); end
      wait_done4(1, 60);
      tick(); tick();
      n_checks++; if (done_cyc_q.size() != 1) begin n_fail++; $display("FAIL basic_done_count got %0d exp 1", done_cyc_q.size()); end
      else begin
         n_checks++; if (done_cyc_q[0] != t + 18) begin n_fail++; $display("FAIL basic_done_cycle got %0d exp %0d", done_cyc_q[0], t + 18); end
      end
      n_checks++; if (ce_q.size() != 16) begin n_fail++; $display("FAIL basic_ce_count got %0d exp 16", ce_q.size()); end
      for (int i = 0; i < ce_q.size() && i < 16; i++) begin
         n_checks++;
         if (ce_q[i] !== N'(i) || ce_cyc_q[i] != t + 2 + i) begin
            n_fail++; $display("FAIL basic_pixel_%0d got data=%0d cyc=%0d exp data=%0d cyc=%0d", i, ce_q[i], ce_cyc_q[i], i, t + 2 + i);
         end
      end
      for (int i = 0; i < 16; i++) if (i / 4 >= 2 && i % 4 >= 2) exp_q.push_back(N'(i));
      n_checks++; if (wv_q.size() != exp_q.size()) begin n_fail++; $display("FAIL basic_wv_count got %0d exp %0d", wv_q.size(), exp_q.size()); end
      for (int i = 0; i < wv_q.size() && i < exp_q.size(); i++) begin
         n_checks++; if (wv_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL basic_wv_%0d got %0d exp %0d", i, wv_q[i], exp_q[i]); end
      end
      n_checks++; if (busy4 !== 1'b0 || bad_addr != 0) begin
         n_fail++; $display("FAIL basic_end got busy=%b bad_addr=%0d exp 0/0", busy4, bad_addr);
      end
   endtask

   task automatic test_stall;
      int t, ec;
      clear_mon();
      start4 = 1'b1; t = cyc; tick(); start4 = 1'b0;
      while (cyc < t + 7) tick();
      // Address 5 was issued in cycle t+6; hold off the next three cycles.
      stall4 = 1'b1;
      tick(); tick(); tick();
      stall4 = 1'b0;
      wait_done4(1, 60);
      tick();
      n_checks++; if (done_cyc_q.size() != 1) begin n_fail++; $display("FAIL stall_done_count got %0d exp 1", done_cyc_q.size()); end
      else begin
         n_checks++; if (done_cyc_q[0] != t + 21) begin n_fail++; $display("FAIL stall_done_cycle got %0d exp %0d", done_cyc_q[0], t + 21); end
      end
      n_checks++; if (ce_q.size() != 16) begin n_fail++; $display("FAIL stall_ce_count got %0d exp 16", ce_q.size()); end
      for (int i = 0; i < ce_q.size() && i < 16; i++) begin
         ec = (i <= 5) ? t + 2 + i : t + 5 + i;
         n_checks++;
         if (ce_q[i] !== N'(i) || ce_cyc_q[i] != ec) begin
            n_fail++; $display("FAIL stall_pixel_%0d got data=%0d cyc=%0d exp data=%0d cyc=%0d", i, ce_q[i], ce_cyc_q[i], i, ec);
         end
      end
      n_checks++; if (en_during_stall != 0) begin n_fail++; $display("FAIL stall_mem_en got %0d reads exp 0", en_during_stall); end
   endtask

   task automatic test_stall_at_start;
      int t;
      clear_mon();
      stall4 = 1'b1; start4 = 1'b1; t = cyc; tick(); start4 = 1'b0;
      n_checks++; if (busy4 !== 1'b1 || mem_en4 !== 1'b0) begin
         n_fail++; $display("FAIL stall_start_enter got busy=%b mem_en=%b exp 1/0", busy4, mem_en4);
      end
      tick(); tick();
      n_checks++; if (mem_en4 !== 1'b0) begin n_fail++; $display("FAIL stall_start_hold got mem_en=%b exp 0", mem_en4); end
      stall4 = 1'b0;
      #1;
      n_checks++; if (mem_en4 !== 1'b1 || mem_addr4 !== 16'd0) begin
         n_fail++; $display("FAIL stall_start_first got mem_en=%b addr=%0d exp 1/0", mem_en4, mem_addr4);
      end
      wait_done4(1, 60);
      tick();
      n_checks++; if (done_cyc_q.size() != 1 || ce_q.size() != 16) begin
         n_fail++; $display("FAIL stall_start_counts got done=%0d ce=%0d exp 1/16", done_cyc_q.size(), ce_q.size());
      end else begin
         n_checks++; if (done_cyc_q[0] != t + 20) begin n_fail++; $display("FAIL stall_start_done_cycle got %0d exp %0d", done_cyc_q[0], t + 20); end
         for (int i = 0; i < 16; i++) begin
            n_checks++; if (ce_q[i] !== N'(i)) begin n_fail++; $display("FAIL stall_start_pixel_%0d got %0d exp %0d", i, ce_q[i], i); end
         end
      end
   endtask

   task automatic test_back_to_back;
      int t;
      clear_mon();
      start4 = 1'b1; t = cyc;
      wait_done4(2, 100);
      start4 = 1'b0;
      tick(); tick(); tick(); tick(); tick();
      n_checks++; if (done_cyc_q.size() != 2) begin n_fail++; $display("FAIL b2b_done_count got %0d exp 2", done_cyc_q.size()); end
      else begin
         n_checks++; if (done_cyc_q[0] != t + 18 || done_cyc_q[1] != t + 37) begin
            n_fail++; $display("FAIL b2b_done_cycles got %0d,%0d exp %0d,%0d", done_cyc_q[0], done_cyc_q[1], t + 18, t + 37);
         end
      end
      n_checks++; if (ce_q.size() != 32) begin n_fail++; $display("FAIL b2b_ce_count got %0d exp 32", ce_q.size()); end
      for (int i = 0; i < ce_q.size() && i < 32; i++) begin
         n_checks++; if (ce_q[i] !== N'(i % 16)) begin n_fail++; $display("FAIL b2b_pixel_%0d got %0d exp %0d", i, ce_q[i], i % 16); end
      end
      n_checks++; if (busy4 !== 1'b0) begin n_fail++; $display("FAIL b2b_idle got busy=%b exp 0", busy4); end
   endtask

   task automatic test_reset_mid_run;
      int t;
      clear_mon();
      start4 = 1'b1; t = cyc; tick(); start4 = 1'b0;
      while (cyc < t + 9) tick();
      // Address 7 went out in cycle t+8.
      rst = 1'b1;
      tick();
      n_checks++; if (mem_en4 !== 1'b0 || mem_addr4 !== 16'd0 || data_out4 !== '0) begin
         n_fail++; $display("FAIL midrst_mem got en=%b addr=%0d data=%0d exp 0/0/0", mem_en4, mem_addr4, data_out4);
      end
      n_checks++; if (ce4 !== 1'b0 || wv4 !== 1'b0 || busy4 !== 1'b0 || done4 !== 1'b0) begin
         n_fail++; $display("FAIL midrst_ctl got ce=%b wv=%b busy=%b done=%b exp 0/0/0/0", ce4, wv4, busy4, done4);
      end
      rst = 1'b0;
      for (int i = 0; i < 25; i++) tick();
      n_checks++; if (ce_q.size() != 8 || done_cyc_q.size() != 0) begin
         n_fail++; $display("FAIL midrst_abort got ce=%0d done=%0d exp 8/0", ce_q.size(), done_cyc_q.size());
      end
      clear_mon();
      start4 = 1'b1; tick(); start4 = 1'b0;
      wait_done4(1, 60);
      tick();
      n_checks++; if (ce_q.size() != 16 || done_cyc_q.size() != 1) begin
         n_fail++; $display("FAIL midrst_rerun got ce=%0d done=%0d exp 16/1", ce_q.size(), done_cyc_q.size());
      end
      for (int i = 0; i < ce_q.size() && i < 16; i++) begin
         n_checks++; if (ce_q[i] !== N'(i)) begin n_fail++; $display("FAIL midrst_pixel_%0d got %0d exp %0d", i, ce_q[i], i); end
      end
   endtask

   task automatic test_defaults;
      int k;
      ce8_cnt = 0; wv8_cnt = 0; done8_cnt = 0; seq8_err = 0; max_addr8 = -1;
      start8 = 1'b1; tick(); start8 = 1'b0;
      k = 0;
      while (done8_cnt == 0 && k < 150) begin tick(); k++; end
      tick();
      n_checks++; if (done8_cnt != 1) begin n_fail++; $display("FAIL def_done_count got %0d exp 1", done8_cnt); end
      n_checks++; if (ce8_cnt != 64) begin n_fail++; $display("FAIL def_ce_count got %0d exp 64", ce8_cnt); end
      n_checks++; if (wv8_cnt != 36) begin n_fail++; $display("FAIL def_wv_count got %0d exp 36", wv8_cnt); end
      n_checks++; if (max_addr8 != 63) begin n_fail++; $display("FAIL def_max_addr got %0d exp 63", max_addr8); end
      n_checks++; if (seq8_err != 0) begin n_fail++; $display("FAIL def_sequence got %0d out-of-order exp 0", seq8_err); end
   endtask

   // ---------------- sequence + report ----------------
   initial begin
      rst = 1'b1; start4 = 1'b0; stall4 = 1'b0; start8 = 1'b0; stall8 = 1'b0;
      ce8_cnt = 0; wv8_cnt = 0; done8_cnt = 0; seq8_err = 0; max_addr8 = -1;
      en_during_stall = 0; bad_addr = 0;
      test_reset();
      test_basic();
      test_stall();
      test_stall_at_start();
      test_back_to_back();
      test_reset_mid_run();
      test_defaults();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/feature_map_streamer.md
FEATURE_MAP_STREAMER -- requirements
Module: feature_map_streamer

Interface
REQ-001 SHALL have parameter N, default 16, meaning pixel data width in bits.
REQ-002 SHALL have parameter W, default 8, meaning feature-map width in pixels (W >= K).
REQ-003 SHALL have parameter H, default 8, meaning feature-map height in rows (H >= K).
REQ-004 SHALL have parameter K, default 3, meaning convolution kernel size.
REQ-005 SHALL have parameter ADDR_W, default 16, meaning memory address width (2^ADDR_W >= W*H).
REQ-006 SHALL have port clk  input  1  system clock; the single clock, all logic on its rising edge.
REQ-007 SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-008 SHALL have port start  input  1  one-cycle request to stream one feature map.
REQ-009 SHALL have port stall  input  1  while high, no new memory read is issued.
REQ-010 SHALL have port mem_en  output  1  memory read enable.
REQ-011 SHALL have port mem_addr  output  ADDR_W  read address, row-major, base 0.
REQ-012 SHALL have port mem_data  input  N  read data, valid exactly one cycle after mem_en.
REQ-013 SHALL have port data_out  output  N  pixel to the line-buffer shift registers.
REQ-014 SHALL have port ce  output  1  shift enable; high exactly in cycles where data_out carries a new pixel.
REQ-015 SHALL have port window_valid  output  1  current pixel completes a full KxK window.
REQ-016 SHALL have port busy  output  1  high in every state except IDLE.
REQ-017 SHALL have port done  output  1  one-cycle completion pulse.

Function
REQ-018 SHALL implement FSM states IDLE, STREAM, DRAIN, DONE.
REQ-019 IDLE: start=1 -> STREAM next cycle, read address counter cleared to 0; start=0 -> stay.
REQ-020 STREAM: each cycle with stall=0, SHALL assert mem_en with mem_addr = counter and then increment the counter; with stall=1, mem_en=0 and counter held.
REQ-021 STREAM: the cycle that issues address W*H-1 SHALL transition to DRAIN; no address >= W*H is ever issued.
REQ-022 DRAIN: SHALL last one cycle, emitting the final pixel, then go to DONE.
REQ-023 DONE: SHALL assert done for exactly one cycle, then return to IDLE.
REQ-024 start SHALL be ignored in every state except IDLE, including in DONE.
REQ-025 For each mem_en issued in cycle t, ce=1 and data_out=mem_data SHALL occur in cycle t+1; ce=0 otherwise; data_out holds its last value when ce=0.
REQ-026 stall SHALL NOT suppress a ce already owed by a read issued in the previous cycle.
REQ-027 Output row/col counters SHALL track the pixel on data_out: col increments per ce, wraps W-1 -> 0 with row increment; both cleared on entering STREAM.
REQ-028 window_valid SHALL equal ce AND row >= K-1 AND col >= K-1, for the pixel currently on data_out.
REQ-029 With no stall, start accepted at cycle t SHALL give mem_en in cycles t+1..t+W*H, ce in t+2..t+W*H+1, and done in t+W*H+2.
REQ-030 Stall cycles SHALL extend the schedule in REQ-029 one-for-one, with no pixel dropped, duplicated or reordered.
REQ-031 Exactly W*H ce pulses and (H-K+1)*(W-K+1) window_valid pulses SHALL occur per run.

Reset
REQ-032 rst=1 SHALL, at the next rising edge, force IDLE and clear mem_en, mem_addr, data_out, ce, window_valid, busy, done, and the row/col and address counters to 0.
REQ-033 rst SHALL take priority over start and stall; a reset mid-run SHALL abort it, with no further ce and no done pulse.
REQ-034 The first start after reset deassertion SHALL be accepted normally.

Verification
REQ-035 W=H=4, K=3, mem[i]=i, start pulse, stall=0 -> ce at 16 consecutive cycles with data 0..15, window_valid on data 10,11,14,15, done 18 cycles after start.
REQ-036 Same map, stall high for 3 cycles after address 5 is issued -> data 6 delayed 3 cycles, sequence still 0..15, done at start+21.
REQ-037 start held high continuously, including through DONE -> runs back to back, each with 16 ce and one done, no overlap.
REQ-038 rst asserted after address 7 is issued -> next cycle: all outputs 0, busy=0, no done; a new start then yields data 0..15.
REQ-039 Defaults W=H=8, K=3 -> 64 ce, 36 window_valid, max mem_addr 63.
REQ-040 stall=1 asserted in the same cycle as start -> STREAM entered, no mem_en until stall=0, first address 0.
